// File: rtl/aes_pkg.sv
// Shared AES package: state/byte types and the column-major byte index
// helper. SubBytes, ShiftRows and MixColumns all address the state through
// byte_idx().
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // s[r][c] lives in byte 4c+r; byte k occupies bits [127-8k -: 8].
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/row_shift_if.sv
// row_shift bus: input state with valid/mode, registered result with valid.
//   master : drives in_valid/inv/aes_in, receives out_valid/row_shift_out
//   slave  : the row_shift stage itself
interface row_shift_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   inv;
  state_t aes_in;
  logic   out_valid;
  state_t row_shift_out;

  modport master (output in_valid, inv, aes_in,
                  input  out_valid, row_shift_out);
  modport slave  (input  in_valid, inv, aes_in,
                  output out_valid, row_shift_out);
endinterface

// File: rtl/row_shift_perm.sv
// Combinational (Inv)ShiftRows byte permutation.
//   state_in  : 128-bit input state
//   inv       : 0 = rotate row r left by r, 1 = rotate right by r
//   state_out : permuted state
// Pure wiring plus one 2:1 mux per byte; usable unregistered by wrappers.
module row_shift_perm
  import aes_pkg::*;
(
  input  state_t state_in,
  input  logic   inv,
  output state_t state_out
);

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int DST = byte_idx(r, c);
      localparam int FWD = byte_idx(r, (c + r) % NUM_COLS);
      // +NUM_COLS keeps the modulo operand non-negative
      localparam int INV = byte_idx(r, (c - r + NUM_COLS) % NUM_COLS);

      assign state_out[127-8*DST -: 8] = inv ? state_in[127-8*INV -: 8]
                                             : state_in[127-8*FWD -: 8];
    end
  end

endmodule

// File: rtl/row_shift.sv
// AES ShiftRows / InvShiftRows stage with one-cycle registered latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : row_shift_if slave (in_valid/inv/aes_in in,
//                out_valid/row_shift_out out)
// Output data holds its last value when no new state arrives.
module row_shift
  import aes_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  row_shift_if.slave bus
);

  state_t perm;
  state_t out_d, out_q;
  logic   vld_d, vld_q;

  row_shift_perm u_perm (
    .state_in  (bus.aes_in),
    .inv       (bus.inv),
    .state_out (perm)
  );

  always_comb begin
    out_d = out_q;
    vld_d = bus.in_valid;
    if (bus.in_valid) out_d = perm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.out_valid     = vld_q;
  assign bus.row_shift_out = out_q;

endmodule

// File: tb/tb_row_shift.sv
module tb_row_shift;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  row_shift_if bus ();

  row_shift dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: unpack to a 4x4 matrix, rotate each row r by r single steps.
  function automatic state_t ref_shift(input state_t s, input bit inv);
    byte_t m[4][4];
    byte_t t;
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int n = 0; n < r; n++) begin
        if (!inv) begin
          t = m[r][0];
          for (int c = 0; c < 3; c++) m[r][c] = m[r][c+1];
          m[r][3] = t;
        end else begin
          t = m[r][3];
          for (int c = 3; c > 0; c--) m[r][c] = m[r][c-1];
          m[r][0] = t;
        end
      end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = m[r][c];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an input right after a falling edge, then return at the next
  // falling edge, i.e. half a cycle after the capturing rising edge.
  task automatic step(input logic v, input logic iv, input state_t d);
    bus.in_valid = v;
    bus.inv      = iv;
    bus.aes_in   = d;
    @(negedge clk);
  endtask

  localparam state_t V1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam state_t V1F = 128'h00050A0F04090E03080D02070C01060B;
  localparam state_t V2  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam state_t V2F = 128'h01AB45EF8923CD6701AB45EF8923CD67;

  initial begin
    state_t r, f, held;
    logic   iv;
    bus.in_valid = 1'b0;
    bus.inv      = 1'b0;
    bus.aes_in   = '0;

    // reset state
    #3;
    check("reset_valid", {127'b0, bus.out_valid}, 128'h0);
    check("reset_data", bus.row_shift_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors
    step(1'b1, 1'b0, V1);
    check("fwd_v1_valid", {127'b0, bus.out_valid}, 128'h1);
    check("fwd_v1", bus.row_shift_out, V1F);
    check("fwd_v1_model", ref_shift(V1, 1'b0), V1F);
    step(1'b1, 1'b0, V2);
    check("fwd_v2", bus.row_shift_out, V2F);
    step(1'b1, 1'b1, V1F);
    check("inv_v3", bus.row_shift_out, V1);

    // idle: valid drops, data holds
    step(1'b0, 1'b1, V2);
    check("idle_valid", {127'b0, bus.out_valid}, 128'h0);
    check("idle_hold", bus.row_shift_out, V1);

    // streaming, mixed modes back-to-back
    step(1'b1, 1'b0, V1);
    check("stream0_valid", {127'b0, bus.out_valid}, 128'h1);
    check("stream0", bus.row_shift_out, V1F);
    step(1'b1, 1'b1, V1F);
    check("stream1_valid", {127'b0, bus.out_valid}, 128'h1);
    check("stream1", bus.row_shift_out, V1);
    step(1'b0, 1'b0, '0);
    check("stream_end_valid", {127'b0, bus.out_valid}, 128'h0);
    check("stream_end_hold", bus.row_shift_out, V1);

    // random round trips: forward, then feed the result back inverted
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, 1'b0, r);
      f = bus.row_shift_out;
      check("rand_fwd", f, ref_shift(r, 1'b0));
      step(1'b1, 1'b1, f);
      check("rand_roundtrip", bus.row_shift_out, r);
    end

    // random mode/valid mix with hold tracking
    held = bus.row_shift_out;
    for (int i = 0; i < 24; i++) begin
      r  = {$urandom, $urandom, $urandom, $urandom};
      iv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, iv, r);
        held = ref_shift(r, iv);
        check("mix_valid", {127'b0, bus.out_valid}, 128'h1);
      end else begin
        step(1'b0, iv, r);
        check("mix_idle_valid", {127'b0, bus.out_valid}, 128'h0);
      end
      check("mix_data", bus.row_shift_out, held);
    end

    // asynchronous reset mid-stream while out_valid is high
    step(1'b1, 1'b0, V2);
    check("pre_rst_valid", {127'b0, bus.out_valid}, 128'h1);
    bus.in_valid = 1'b1;
    bus.aes_in   = V1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'b0, bus.out_valid}, 128'h0);
    check("async_rst_data", bus.row_shift_out, 128'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_valid", {127'b0, bus.out_valid}, 128'h0);
    step(1'b1, 1'b0, V2);
    check("post_rst_valid", {127'b0, bus.out_valid}, 128'h1);
    check("post_rst_data", bus.row_shift_out, V2F);
    step(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
